// File: rtl/spi_rx_mode_pkg.sv
// Shared types for the SPI slave receiver: mode encoding, FSM states, width helper.
package spi_rx_mode_pkg;

  // Encoded as {CPOL, CPHA}
  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } spi_mode_e;

  typedef enum logic [1:0] {
    ST_RESYNC,
    ST_IDLE,
    ST_SHIFT
  } rx_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Data is captured on the rising SCLK edge when CPOL and CPHA agree.
  function automatic logic sample_on_rise(input spi_mode_e mode);
    return ~(mode[1] ^ mode[0]);
  endfunction

endpackage

// File: rtl/spi_rx_mode_if.sv
// SPI pins plus the received-word valid/ready stream and status pulses.
interface spi_rx_mode_if #(
  parameter int DATA_W = 8
);
  logic              spi_sclk;
  logic              spi_cs_n;
  logic              spi_mosi;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              frame_err;
  logic              overrun;
  logic              busy;

  modport master (
    output spi_sclk, spi_cs_n, spi_mosi, rx_ready,
    input  rx_data, rx_valid, frame_err, overrun, busy
  );

  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi, rx_ready,
    output rx_data, rx_valid, frame_err, overrun, busy
  );
endinterface

// File: rtl/spi_sync_edge.sv
// Synchronises SCLK/CS_n/MOSI into the system clock and flags the sampling SCLK edge.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit SAMPLE_RISE = 1'b1,
  parameter bit SCLK_IDLE   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic sample_pulse,
  output logic cs_n_s,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] cs_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   sclk_d;
  logic                   sclk_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q <= {SYNC_STAGES{SCLK_IDLE}};
      cs_q   <= '1;
      mosi_q <= '0;
      sclk_d <= SCLK_IDLE;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
      cs_q   <= {cs_q[SYNC_STAGES-2:0], cs_n};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
      sclk_d <= sclk_s;
    end
  end

  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign cs_n_s = cs_q[SYNC_STAGES-1];
  // MOSI tapped at the same depth as SCLK so the sampled bit lines up with the edge.
  assign mosi_s = mosi_q[SYNC_STAGES-1];

  assign sample_pulse = SAMPLE_RISE ? (sclk_s & ~sclk_d) : (~sclk_s & sclk_d);

endmodule

// File: rtl/spi_rx_mode.sv
// SPI slave receiver: oversampled deserialiser, word FIFO with valid/ready output,
// frame-error and overrun pulses.
module spi_rx_mode
  import spi_rx_mode_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic          RST_clk,
  input  logic          RST_n,
  spi_rx_mode_if.slave  bus
);

  localparam bit        CPOL_B = (CPOL != 0);
  localparam bit        CPHA_B = (CPHA != 0);
  localparam spi_mode_e MODE   = spi_mode_e'({CPOL_B, CPHA_B});
  localparam int        CNT_W  = clog2(DATA_W);
  localparam int        AW     = clog2(FIFO_DEPTH);
  localparam int        SET_W  = clog2(SYNC_STAGES + 1);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [SET_W-1:0] SETTLE   = SET_W'(SYNC_STAGES);
  localparam logic [AW:0]      FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  logic sample_pulse;
  logic cs_n_s;
  logic mosi_s;

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .SAMPLE_RISE (sample_on_rise(MODE)),
    .SCLK_IDLE   (CPOL_B)
  ) u_sync (
    .clk          (RST_clk),
    .rst          (RST_n),
    .sclk         (bus.spi_sclk),
    .cs_n         (bus.spi_cs_n),
    .mosi         (bus.spi_mosi),
    .sample_pulse (sample_pulse),
    .cs_n_s       (cs_n_s),
    .mosi_s       (mosi_s)
  );

  rx_state_e         state, state_nxt;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt, shifted;
  logic [SET_W-1:0]  settle_cnt, settle_nxt;
  logic              word_done;
  logic              push;
  logic              ferr_c;

  always_ff @(posedge RST_clk or posedge RST_n) begin
    if (RST_n) begin
      state      <= ST_RESYNC;
      bit_cnt    <= '0;
      shreg      <= '0;
      settle_cnt <= '0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shreg      <= shreg_nxt;
      settle_cnt <= settle_nxt;
    end
  end

  assign shifted   = (MSB_FIRST != 0) ? {shreg[DATA_W-2:0], mosi_s}
                                      : {mosi_s, shreg[DATA_W-1:1]};
  assign word_done = sample_pulse && (bit_cnt == LAST_BIT);

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    settle_nxt  = settle_cnt;
    push        = 1'b0;
    ferr_c      = 1'b0;
    case (state)
      // Wait for the synchronisers to flush, then for a genuine CS_n high,
      // so a frame already running at reset release is skipped.
      ST_RESYNC: begin
        if (settle_cnt != SETTLE) begin
          settle_nxt = settle_cnt + 1'b1;
        end else if (cs_n_s) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (!cs_n_s) begin
          state_nxt   = ST_SHIFT;
          bit_cnt_nxt = '0;
          shreg_nxt   = '0;
        end
      end
      ST_SHIFT: begin
        if (sample_pulse) begin
          shreg_nxt   = shifted;
          bit_cnt_nxt = word_done ? '0 : bit_cnt + 1'b1;
          push        = word_done;
        end
        if (cs_n_s) begin
          state_nxt = ST_IDLE;
          ferr_c    = (bit_cnt != '0) && !word_done;
        end
      end
      default: state_nxt = ST_RESYNC;
    endcase
  end

  assign bus.busy = (state == ST_SHIFT);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              full;
  logic              pop;
  logic              wr_en;
  logic              rx_valid;
  logic              frame_err_q;
  logic              overrun_q;

  assign rx_valid = (count != '0);
  assign full     = (count == FULL_CNT);
  assign pop      = rx_valid & bus.rx_ready;
  // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
  assign wr_en    = push & (~full | pop);

  always_ff @(posedge RST_clk or posedge RST_n) begin
    if (RST_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= shifted;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count       <= count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};
      frame_err_q <= ferr_c;
      overrun_q   <= push & full & ~pop;
    end
  end

  assign bus.rx_data   = mem[rd_ptr];
  assign bus.rx_valid  = rx_valid;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_spi_rx_mode.sv
// Bench for spi_rx_mode: four instances covering mode 0 MSB/LSB, mode 3 and mode 1.
`timescale 1ns/1ps
module tb_spi_rx_mode;

  localparam int         HALF   = 4;
  localparam logic [3:0] CPOL_T = 4'b0100;
  localparam logic [3:0] CPHA_T = 4'b1100;
  localparam logic [3:0] MSB_T  = 4'b1101;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sclk_v;
  logic [3:0] cs_v;
  logic [3:0] rdy_v;
  logic       mosi;

  logic [7:0] data_o [4];
  logic [3:0] vld_o, busy_o, ferr_o, ovr_o;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_rx_mode_if #(.DATA_W(8)) bus ();
    assign bus.spi_sclk = sclk_v[g];
    assign bus.spi_cs_n = cs_v[g];
    assign bus.spi_mosi = mosi;
    assign bus.rx_ready = rdy_v[g];
    assign data_o[g]    = bus.rx_data;
    assign vld_o[g]     = bus.rx_valid;
    assign busy_o[g]    = bus.busy;
    assign ferr_o[g]    = bus.frame_err;
    assign ovr_o[g]     = bus.overrun;

    spi_rx_mode #(
      .DATA_W      (8),
      .CPOL        (int'(CPOL_T[g])),
      .CPHA        (int'(CPHA_T[g])),
      .MSB_FIRST   (int'(MSB_T[g])),
      .SYNC_STAGES (2),
      .FIFO_DEPTH  (4)
    ) dut (
      .RST_clk (clk),
      .RST_n   (rst),
      .bus     (bus)
    );
  end

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         last_edge_cyc = 0;
  int         ferr_cnt [4] = '{default: 0};
  int         ovr_cnt  [4] = '{default: 0};
  int         rise_cyc [4] = '{default: 0};
  logic [3:0] vld_prev = '0;
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      if (ferr_o[g] === 1'b1) ferr_cnt[g]++;
      if (ovr_o[g] === 1'b1) ovr_cnt[g]++;
      if (vld_o[g] === 1'b1 && vld_prev[g] !== 1'b1) rise_cyc[g] = cyc;
      vld_prev[g] = vld_o[g];
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cs_set(input int g, input logic v);
    cs_v[g] = v;
    tick(HALF);
  endtask

  // Master side of one word in the mode/bit order of instance g.
  task automatic spi_bits(input int g, input logic [7:0] d, input int nbits);
    logic b;
    for (int i = 0; i < nbits; i++) begin
      b = MSB_T[g] ? d[nbits-1-i] : d[i];
      if (!CPHA_T[g]) begin
        mosi = b;
        tick(HALF);
        sclk_v[g] = ~CPOL_T[g];
        last_edge_cyc = cyc;
        tick(HALF);
        sclk_v[g] = CPOL_T[g];
      end else begin
        sclk_v[g] = ~CPOL_T[g];
        mosi = b;
        tick(HALF);
        sclk_v[g] = CPOL_T[g];
        last_edge_cyc = cyc;
        tick(HALF);
      end
    end
  endtask

  // Collects up to n words from instance g into got_q; stops early on timeout.
  task automatic drain(input int g, input int n);
    int w;
    got_q.delete();
    rdy_v[g] = 1'b1;
    for (int k = 0; k < n; k++) begin
      w = 0;
      @(negedge clk);
      while (vld_o[g] !== 1'b1 && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (vld_o[g] !== 1'b1) break;
      got_q.push_back(data_o[g]);
      @(posedge clk);
      #1;
    end
    rdy_v[g] = 1'b0;
  endtask

  task automatic test_reset();
    tick(3);
    @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      checks++; if (vld_o[g] !== 1'b0) begin failures++; $display("FAIL reset_valid[%0d]: got %b want 0", g, vld_o[g]); end
      checks++; if (data_o[g] !== 8'h00) begin failures++; $display("FAIL reset_data[%0d]: got %h want 00", g, data_o[g]); end
      checks++; if (ferr_o[g] !== 1'b0) begin failures++; $display("FAIL reset_frame_err[%0d]: got %b want 0", g, ferr_o[g]); end
      checks++; if (ovr_o[g] !== 1'b0) begin failures++; $display("FAIL reset_overrun[%0d]: got %b want 0", g, ovr_o[g]); end
      checks++; if (busy_o[g] !== 1'b0) begin failures++; $display("FAIL reset_busy[%0d]: got %b want 0", g, busy_o[g]); end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    tick(10);
  endtask

  task automatic test_mode0();
    int f0;
    exp_q.delete();
    f0 = ferr_cnt[0];
    exp_q.push_back(8'hA5);
    cs_set(0, 1'b0);
    spi_bits(0, 8'hA5, 8);
    checks++;
    if (rise_cyc[0] - last_edge_cyc != 3) begin
      failures++; $display("FAIL mode0_latency: got %0d cycles want 3", rise_cyc[0] - last_edge_cyc);
    end
    cs_set(0, 1'b1);
    tick(4);
    checks++; if (ferr_cnt[0] != f0) begin failures++; $display("FAIL mode0_frame_err: got %0d pulses want 0", ferr_cnt[0] - f0); end
    drain(0, 1);
    checks++; if (got_q.size() != 1) begin failures++; $display("FAIL mode0_count: got %0d words want 1", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL mode0_data: got %h want %h", got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_lsb_first();
    exp_q.delete();
    exp_q.push_back(8'hA5);
    cs_set(1, 1'b0);
    spi_bits(1, 8'hA5, 8);
    cs_set(1, 1'b1);
    drain(1, 1);
    checks++; if (got_q.size() != 1) begin failures++; $display("FAIL lsb_count: got %0d words want 1", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL lsb_data: got %h want %h", got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int f0;
    exp_q.delete();
    f0 = ferr_cnt[2];
    cs_set(2, 1'b0);
    checks++; if (busy_o[2] !== 1'b1) begin failures++; $display("FAIL b2b_busy_start: got %b want 1", busy_o[2]); end
    exp_q.push_back(8'h3C);
    spi_bits(2, 8'h3C, 8);
    checks++; if (busy_o[2] !== 1'b1) begin failures++; $display("FAIL b2b_busy_mid: got %b want 1", busy_o[2]); end
    checks++; if (vld_o[2] !== 1'b1) begin failures++; $display("FAIL b2b_first_valid: got %b want 1", vld_o[2]); end
    exp_q.push_back(8'hC3);
    spi_bits(2, 8'hC3, 8);
    checks++; if (busy_o[2] !== 1'b1) begin failures++; $display("FAIL b2b_busy_end: got %b want 1", busy_o[2]); end
    cs_set(2, 1'b1);
    tick(4);
    checks++; if (busy_o[2] !== 1'b0) begin failures++; $display("FAIL b2b_busy_idle: got %b want 0", busy_o[2]); end
    checks++; if (ferr_cnt[2] != f0) begin failures++; $display("FAIL b2b_frame_err: got %0d pulses want 0", ferr_cnt[2] - f0); end
    drain(2, 2);
    checks++; if (got_q.size() != 2) begin failures++; $display("FAIL b2b_count: got %0d words want 2", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_frame_err();
    int f0;
    exp_q.delete();
    f0 = ferr_cnt[3];
    cs_set(3, 1'b0);
    spi_bits(3, 8'h16, 5);
    cs_set(3, 1'b1);
    tick(4);
    checks++; if (ferr_cnt[3] - f0 != 1) begin failures++; $display("FAIL ferr_pulses: got %0d want 1", ferr_cnt[3] - f0); end
    checks++; if (vld_o[3] !== 1'b0) begin failures++; $display("FAIL ferr_valid: got %b want 0", vld_o[3]); end
    exp_q.push_back(8'h5A);
    cs_set(3, 1'b0);
    spi_bits(3, 8'h5A, 8);
    cs_set(3, 1'b1);
    drain(3, 1);
    checks++; if (got_q.size() != 1) begin failures++; $display("FAIL ferr_next_count: got %0d words want 1", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL ferr_next_data: got %h want %h", got_q[i], exp_q[i]); end
    end
    checks++; if (ferr_cnt[3] - f0 != 1) begin failures++; $display("FAIL ferr_total: got %0d want 1", ferr_cnt[3] - f0); end
  endtask

  task automatic test_overrun();
    int o0;
    exp_q.delete();
    o0 = ovr_cnt[0];
    rdy_v[0] = 1'b0;
    cs_set(0, 1'b0);
    for (int v = 1; v <= 5; v++) begin
      if (v <= 4) exp_q.push_back(8'(v));
      spi_bits(0, 8'(v), 8);
      if (v == 4) begin
        checks++; if (ovr_cnt[0] != o0) begin failures++; $display("FAIL ovr_early: got %0d pulses want 0", ovr_cnt[0] - o0); end
      end
    end
    checks++; if (ovr_cnt[0] - o0 != 1) begin failures++; $display("FAIL ovr_pulses: got %0d want 1", ovr_cnt[0] - o0); end
    cs_set(0, 1'b1);
    drain(0, 4);
    checks++; if (got_q.size() != 4) begin failures++; $display("FAIL ovr_count: got %0d words want 4", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL ovr_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    @(negedge clk);
    checks++; if (vld_o[0] !== 1'b0) begin failures++; $display("FAIL ovr_empty: got %b want 0", vld_o[0]); end
  endtask

  task automatic test_reset_mid();
    int f0;
    exp_q.delete();
    rdy_v[0] = 1'b0;
    cs_set(0, 1'b0);
    spi_bits(0, 8'h77, 8);
    cs_set(0, 1'b1);
    checks++; if (vld_o[0] !== 1'b1) begin failures++; $display("FAIL rmid_preload: got %b want 1", vld_o[0]); end
    cs_set(0, 1'b0);
    spi_bits(0, 8'h07, 3);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    f0 = ferr_cnt[0];
    spi_bits(0, 8'h5F, 8);
    cs_set(0, 1'b1);
    tick(8);
    @(negedge clk);
    checks++; if (vld_o[0] !== 1'b0) begin failures++; $display("FAIL rmid_valid: got %b want 0", vld_o[0]); end
    checks++; if (data_o[0] !== 8'h00) begin failures++; $display("FAIL rmid_data: got %h want 00", data_o[0]); end
    checks++; if (ferr_cnt[0] != f0) begin failures++; $display("FAIL rmid_frame_err: got %0d pulses want 0", ferr_cnt[0] - f0); end
    tick(1);
    exp_q.push_back(8'h81);
    cs_set(0, 1'b0);
    spi_bits(0, 8'h81, 8);
    cs_set(0, 1'b1);
    drain(0, 1);
    checks++; if (got_q.size() != 1) begin failures++; $display("FAIL rmid_next_count: got %0d words want 1", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rmid_next_data: got %h want %h", got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    #300us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    sclk_v = CPOL_T;
    cs_v   = '1;
    rdy_v  = '0;
    mosi   = 1'b0;
    test_reset();
    test_mode0();
    test_lsb_first();
    test_back_to_back();
    test_frame_err();
    test_overrun();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_rx_mode.md
Name: spi_rx_mode

Overview:
Parametrised SPI slave receiver for the ADC data path. Runs entirely on the system clock: SCLK, CS_n and MOSI are oversampled through synchronisers.
Supports all four CPOL/CPHA modes, configurable word width and MSB- or LSB-first order, and back-to-back words within one chip-select window. Received words are buffered in a small FIFO behind a valid/ready handshake, with framing-error and overrun reporting.

Parameters:
DATA_W, 8, bits per word (2..32)
CPOL, 0, SCLK idle level
CPHA, 0, 0 = sample on first SCLK edge, 1 = sample on second SCLK edge
MSB_FIRST, 1, 1 = first received bit lands in rx_data[DATA_W-1]; 0 = first bit lands in rx_data[0]
SYNC_STAGES, 2, synchroniser depth on SCLK/CS_n/MOSI (>=2)
FIFO_DEPTH, 4, word buffer depth (power of two, >=2)

Ports:
RST_clk  in  1  system clock; must be >= 4x SCLK frequency
RST_n  in  1  asynchronous active-high reset
spi_sclk  in  1  SPI clock from master
spi_cs_n  in  1  chip select, active low
spi_mosi  in  1  serial data in
rx_data  out  DATA_W  FIFO head word
rx_valid  out  1  FIFO non-empty
rx_ready  in  1  consumer accepts head word when high with rx_valid
frame_err  out  1  one-cycle pulse: CS_n rose with partial word
overrun  out  1  one-cycle pulse: completed word dropped because FIFO full
busy  out  1  FSM in SHIFT

Behaviour:
- Synchronisers reset to idle levels: sclk = CPOL, cs_n = 1, mosi = 0.
- Edge detect compares the last two synchronised SCLK samples.
- Sample edge is rising when CPOL^CPHA = 0, falling otherwise. The other edge is ignored.
- MOSI is taken from the same synchroniser stage as SCLK.
- FSM states: RESYNC, IDLE, SHIFT.
  - Reset -> RESYNC.
  - RESYNC -> IDLE when synced cs_n = 1. A frame already in progress at reset release is ignored entirely.
  - IDLE -> SHIFT when synced cs_n = 0. On this transition bit_cnt = 0 and the shift register is cleared.
  - SHIFT, on a sample edge: shift MOSI in (left shift if MSB_FIRST, else right shift), then bit_cnt += 1.
  - SHIFT, when bit_cnt = DATA_W-1 at a sample edge: the completed word is pushed in that cycle, bit_cnt wraps to 0, and the FSM stays in SHIFT for the next word.
  - SHIFT -> IDLE when synced cs_n = 1. If bit_cnt != 0, frame_err pulses for one cycle and the partial word is discarded.
  - A cs_n rise in the same cycle as the final sample edge: the word is pushed and frame_err stays 0.
- Latency: final sample edge detected in cycle N, so the FIFO is written at the end of N and rx_valid = 1 in N+1 if the FIFO was empty.
- FIFO:
  - Pop occurs on rx_valid & rx_ready.
  - Push while full with a simultaneous pop is accepted (no overrun).
  - Push while full without a pop: the word is dropped, overrun pulses for one cycle, and the FIFO contents are unchanged.
  - Read order is first-in first-out. Pointers wrap modulo FIFO_DEPTH, with the count held in log2(FIFO_DEPTH)+1 bits.
  - rx_data is undefined-but-stable when rx_valid = 0. It is driven to 0 after reset.
- Reset values: rx_data = 0, rx_valid = 0, frame_err = 0, overrun = 0, busy = 0. FIFO is emptied and bit_cnt = 0.
- Asserting reset mid-operation clears everything immediately, including stored words.

Decomposition:
- Shared package: spi mode encoding (CPOL/CPHA pairs MODE0..MODE3), FSM state enum, and a clog2 helper constant function.
- One natural sub-module, spi_sync_edge: SYNC_STAGES synchroniser for the three inputs plus sample-edge detection. Its outputs are sample_pulse, cs_n_s and mosi_s.
- FIFO stays inline.

Test Plan:
- Mode 0 (CPOL=0, CPHA=0), MSB_FIRST=1: CS low, shift 0xA5, CS high -> single rx_data = 0xA5, rx_valid 1 cycle after the 8th sample edge, frame_err = 0.
- MSB_FIRST=0, master sends 0xA5 LSB-first -> rx_data = 0xA5.
- Mode 3 (CPOL=1, CPHA=1): one CS window carrying 0x3C then 0xC3 -> two FIFO entries, read in order 0x3C, 0xC3; busy high throughout the window.
- Mode 1 (CPOL=0, CPHA=1): 5 bits then CS high -> one frame_err pulse, rx_valid stays 0. Next full frame 0x5A is received correctly.
- rx_ready = 0, FIFO_DEPTH = 4, send 0x01..0x05 -> overrun pulses once on 0x05. Readout 0x01..0x04 and then rx_valid = 0.
- Reset pulsed mid-word with CS held low, finish that frame -> no word. Next CS low window with 0x81 -> rx_data = 0x81.
